// File: rtl/s_spi_slave_sync.sv
// SPI slave running in the system clock domain.
// SCLK/MOSI/SS are synchronised; edges are detected from the synchronised SCLK.
module s_spi_slave_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  SS,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic IDLE_LVL = (CPOL != 0);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sy;
  logic [SYNC_STAGES-1:0] mosi_sy;
  logic [SYNC_STAGES-1:0] ss_sy;
  logic                   sclk_d;
  logic                   ss_d;

  logic [DATA_WIDTH-1:0] txsr;
  logic [DATA_WIDTH-1:0] rxsr;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic                  tx_full;
  logic [CW-1:0]         rx_cnt;
  logic [CW-1:0]         tx_cnt;

  logic sclk_s, mosi_s, ss_s;
  logic lead, trail, sample, launch;
  logic ss_fall, act, frame_end;
  logic launch_ev, sample_ev, word_done;
  logic load, shift, tx_wr;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sy <= {SYNC_STAGES{IDLE_LVL}};
      mosi_sy <= '0;
      ss_sy   <= '1;
      sclk_d  <= IDLE_LVL;
      ss_d    <= 1'b1;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], SCLK};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], MOSI};
      ss_sy   <= {ss_sy[SYNC_STAGES-2:0], SS};
      sclk_d  <= sclk_s;
      ss_d    <= ss_s;
    end
  end

  assign sclk_s = sclk_sy[SYNC_STAGES-1];
  assign mosi_s = mosi_sy[SYNC_STAGES-1];
  assign ss_s   = ss_sy[SYNC_STAGES-1];

  assign lead    = (sclk_s != sclk_d) && (sclk_s != IDLE_LVL);
  assign trail   = (sclk_s != sclk_d) && (sclk_s == IDLE_LVL);
  assign sample  = (CPHA != 0) ? trail : lead;
  assign launch  = (CPHA != 0) ? lead : trail;
  assign ss_fall = ss_d && !ss_s;

  // A rising SS masks any edge seen in the same cycle, so abort wins.
  assign act       = (state == ACTIVE) && !ss_s;
  assign frame_end = (state == ACTIVE) && ss_s;
  assign launch_ev = act && launch;
  assign sample_ev = act && sample;
  assign word_done = sample_ev && (rx_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    MISO_OE = 1'b0;
    unique case (state)
      IDLE: begin
        if (!ss_s) state_n = ACTIVE;
      end
      ACTIVE: begin
        busy    = 1'b1;
        MISO_OE = 1'b1;
        if (ss_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign load = (CPHA == 0)
    ? ((ss_fall && state == IDLE) ||
       (launch_ev && tx_cnt == LAST))
    : (launch_ev && tx_cnt == '0);
  assign shift = launch_ev && !load;
  assign tx_wr = tx_valid && !tx_full;

  assign rx_next = (MSB_FIRST != 0)
    ? {rxsr[DATA_WIDTH-2:0], mosi_s}
    : {mosi_s, rxsr[DATA_WIDTH-1:1]};
  assign tx_shift = (MSB_FIRST != 0)
    ? {txsr[DATA_WIDTH-2:0], 1'b0}
    : {1'b0, txsr[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txsr        <= '0;
      rxsr        <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      rx_cnt      <= '0;
      tx_cnt      <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      if (tx_wr) tx_buf <= tx_data;
      // A load empties the buffer; a same-cycle write refills it.
      if (load) begin
        txsr        <= tx_full ? tx_buf : '0;
        tx_underrun <= !tx_full;
        tx_full     <= tx_wr;
      end else begin
        if (shift) txsr <= tx_shift;
        if (tx_wr) tx_full <= 1'b1;
      end
      if (frame_end) begin
        rx_cnt      <= '0;
        tx_cnt      <= '0;
        frame_abort <= (rx_cnt != '0);
      end else begin
        if (launch_ev) begin
          tx_cnt <= (tx_cnt == LAST) ? '0 : tx_cnt + CW'(1);
        end
        if (sample_ev) begin
          rxsr   <= rx_next;
          rx_cnt <= (rx_cnt == LAST) ? '0 : rx_cnt + CW'(1);
        end
      end
      if (word_done) begin
        rx_data    <= rx_next;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign tx_ready = !tx_full;
  assign MISO = (MSB_FIRST != 0) ? txsr[DATA_WIDTH-1] : txsr[0];

endmodule
